// File: rtl/bullet_pool_pkg.sv
`default_nettype none
// ============================================================================
// bullet_pkg : shared types and widths for the bullet pool
// Revision   : 1.0
// ============================================================================
package bullet_pkg;

  localparam int C_COLOR_W = 3;
  localparam int C_DIR_W   = 2;

  typedef enum logic [C_COLOR_W-1:0] {
    WHITE = 3'b000,
    GREEN = 3'b001,
    BLUE  = 3'b010
  } color_t;

  typedef enum logic [C_DIR_W-1:0] {
    DIR_POS_Y = 2'b00,
    DIR_NEG_Y = 2'b01,
    DIR_POS_X = 2'b10,
    DIR_NEG_X = 2'b11
  } dir_t;

  // Non-coordinate attributes of one pool entry
  typedef struct packed {
    color_t color;
    dir_t   dir;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/bullet_pool_if.sv
`default_nettype none
// ============================================================================
// bullet_pool_if : spawn handshake and collide request bundle
// Revision       : 1.0
// ============================================================================
interface bullet_pool_if #(
  parameter int COORD_W = 8,
  parameter int IDX_W   = 3
);
  logic               spawn_valid;
  logic               spawn_ready;
  logic [COORD_W-1:0] spawn_x;
  logic [COORD_W-1:0] spawn_y;
  logic [COORD_W-1:0] spawn_w;
  logic [COORD_W-1:0] spawn_h;
  logic [2:0]         spawn_color;
  logic [1:0]         spawn_dir;
  logic [IDX_W-1:0]   spawn_idx;
  logic               collide_valid;
  logic [IDX_W-1:0]   collide_idx;

  modport master (
    output spawn_valid, spawn_x, spawn_y, spawn_w, spawn_h,
           spawn_color, spawn_dir, collide_valid, collide_idx,
    input  spawn_ready, spawn_idx
  );

  modport slave (
    input  spawn_valid, spawn_x, spawn_y, spawn_w, spawn_h,
           spawn_color, spawn_dir, collide_valid, collide_idx,
    output spawn_ready, spawn_idx
  );
endinterface
`default_nettype wire

// File: rtl/bullet_free_slot_enc.sv
`default_nettype none
// ============================================================================
// bullet_free_slot_enc : lowest-zero priority encoder over the active mask
// Revision             : 1.0
// ============================================================================
module bullet_free_slot_enc #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     mask_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_free_o
);

  // Scan from the top so the lowest free slot is the last one written
  always_comb begin
    idx_o      = '0;
    any_free_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!mask_i[i]) begin
        idx_o      = IDX_W'(i);
        any_free_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bullet_pool.sv
`default_nettype none
// ============================================================================
// bullet_pool : pool of moving entries with spawn/collide and two read ports
// Revision    : 1.0
// ============================================================================
module bullet_pool
  import bullet_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int COORD_W     = 8,
  parameter int STEP        = 5,
  parameter int LIMIT       = 200,
  parameter int RESTART     = 1,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 clear_all,
  bullet_pool_if.slave         sp,
  input  logic [IDX_W-1:0]     rd_idx_a,
  input  logic [IDX_W-1:0]     rd_idx_b,
  output logic [2*COORD_W-1:0] pos_a,
  output logic [2*COORD_W-1:0] pos_b,
  output logic [2*COORD_W-1:0] size_a,
  output logic [2*COORD_W-1:0] size_b,
  output logic [C_COLOR_W-1:0] color_a,
  output logic [C_COLOR_W-1:0] color_b,
  output logic                 render_a,
  output logic                 render_b,
  output logic [IDX_W:0]       active_count
);

  localparam logic [COORD_W-1:0] C_STEP    = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] C_LIMIT   = COORD_W'(LIMIT);
  localparam logic [COORD_W-1:0] C_RESTART = COORD_W'(RESTART);

  logic [NUM_ENTRIES-1:0] active_q, active_d;
  logic [COORD_W-1:0]     x_q [NUM_ENTRIES];
  logic [COORD_W-1:0]     x_d [NUM_ENTRIES];
  logic [COORD_W-1:0]     y_q [NUM_ENTRIES];
  logic [COORD_W-1:0]     y_d [NUM_ENTRIES];
  logic [COORD_W-1:0]     w_q [NUM_ENTRIES];
  logic [COORD_W-1:0]     w_d [NUM_ENTRIES];
  logic [COORD_W-1:0]     h_q [NUM_ENTRIES];
  logic [COORD_W-1:0]     h_d [NUM_ENTRIES];
  entry_t                 attr_q [NUM_ENTRIES];
  entry_t                 attr_d [NUM_ENTRIES];
  logic [IDX_W:0]         count_q, count_d;

  logic [IDX_W-1:0]       w_free_idx;
  logic                   w_any_free;
  logic                   w_spawn_fire;

  function automatic logic [COORD_W-1:0] step_coord(input logic [COORD_W-1:0] c,
                                                    input logic pos);
    logic [COORD_W:0] sum;
    sum = {1'b0, c} + {1'b0, C_STEP};
    if (pos) step_coord = (c >= C_LIMIT) ? C_RESTART : sum[COORD_W-1:0];
    else     step_coord = (c < C_STEP)   ? C_LIMIT   : c - C_STEP;
  endfunction

  bullet_free_slot_enc #(
    .N     (NUM_ENTRIES),
    .IDX_W (IDX_W)
  ) u_free_slot_enc (
    .mask_i     (active_q),
    .idx_o      (w_free_idx),
    .any_free_o (w_any_free)
  );

  assign sp.spawn_ready = w_any_free & ~clear_all;
  assign sp.spawn_idx   = w_free_idx;
  assign w_spawn_fire   = sp.spawn_valid & sp.spawn_ready;

  // Collide is applied before spawn so it can never cancel a fresh allocation
  always_comb begin
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    w_d      = w_q;
    h_d      = h_q;
    attr_d   = attr_q;
    count_d  = '0;

    if (tick) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (active_q[i]) begin
          case (attr_q[i].dir)
            DIR_POS_Y: y_d[i] = step_coord(y_q[i], 1'b1);
            DIR_NEG_Y: y_d[i] = step_coord(y_q[i], 1'b0);
            DIR_POS_X: x_d[i] = step_coord(x_q[i], 1'b1);
            DIR_NEG_X: x_d[i] = step_coord(x_q[i], 1'b0);
          endcase
        end
      end
    end

    if (sp.collide_valid) active_d[sp.collide_idx] = 1'b0;

    if (w_spawn_fire) begin
      x_d[w_free_idx]          = sp.spawn_x;
      y_d[w_free_idx]          = sp.spawn_y;
      w_d[w_free_idx]          = sp.spawn_w;
      h_d[w_free_idx]          = sp.spawn_h;
      attr_d[w_free_idx].color = color_t'(sp.spawn_color);
      attr_d[w_free_idx].dir   = dir_t'(sp.spawn_dir);
      active_d[w_free_idx]     = 1'b1;
    end

    if (clear_all) active_d = '0;

    for (int i = 0; i < NUM_ENTRIES; i++) begin
      count_d = count_d + {{IDX_W{1'b0}}, active_d[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= '0;
      x_q      <= '{default: '0};
      y_q      <= '{default: '0};
      w_q      <= '{default: '0};
      h_q      <= '{default: '0};
      attr_q   <= '{default: '0};
      count_q  <= '0;
    end else begin
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
      w_q      <= w_d;
      h_q      <= h_d;
      attr_q   <= attr_d;
      count_q  <= count_d;
    end
  end

  assign pos_a        = {x_q[rd_idx_a], y_q[rd_idx_a]};
  assign pos_b        = {x_q[rd_idx_b], y_q[rd_idx_b]};
  assign size_a       = {w_q[rd_idx_a], h_q[rd_idx_a]};
  assign size_b       = {w_q[rd_idx_b], h_q[rd_idx_b]};
  assign color_a      = attr_q[rd_idx_a].color;
  assign color_b      = attr_q[rd_idx_b].color;
  assign render_a     = active_q[rd_idx_a];
  assign render_b     = active_q[rd_idx_b];
  assign active_count = count_q;

endmodule
`default_nettype wire
